wager_controller: RTL and testbench
===================================

// Module: wager_controller
// PURPOSE
//  Sequences betting for the baccarat round: latches and escrows a bet at round start, then settles it at round end.
//  Settlement applies payout rules to the final pscore/dscore and drives the displayed balance.
//  Clocked on the same slow_clock as the round state machine.
//  Consumes the round-start strobe (load_pcard1 pulse) and endround from that state machine.
// PARAMETERS
//  START_BALANCE  100  balance loaded on reset
//  BAL_W          8    balance / bet width, bits
//  TIE_MULT       8    tie-bet odds; winning tie returns (TIE_MULT+1)*bet
// PORTS
//  slow_clock   in   1      sole clock; all state updates on rising edge
//  resetb       in   1      asynchronous, active-low reset
//  round_start  in   1      1-cycle strobe: new round begins
//  endround     in   1      level: round finished, scores final
//  pscore       in   4      player score 0..9
//  dscore       in   4      dealer score 0..9
//  bet_side     in   2      00 none, 01 player, 10 dealer, 11 tie
//  bet_amt      in   BAL_W  requested stake
//  balance      out  BAL_W  current bankroll (stake excluded while escrowed)
//  bet_locked   out  1      1 while a valid bet is escrowed
//  bet_reject   out  1      last start refused the bet (amt > balance)
//  result       out  2      00 none, 01 win, 10 lose, 11 push
//  sat          out  1      sticky: a payout clipped at 2^BAL_W-1
//  broke        out  1      balance==0, combinational
// BEHAVIOUR
//  Reset (async): state IDLE; balance=START_BALANCE; stake=0; side=00.
//    bet_locked=0, bet_reject=0, result=00, sat=0.
//  States: IDLE -> LOCKED -> DONE -> IDLE.
//  IDLE:
//    bet_side/bet_amt are live and unlatched.
//    round_start: result<=00, bet_reject<=0, then:
//      side==00 or amt==0: stake<=0, side<=00, bet_locked<=0.
//      amt>balance: same as no-bet, but bet_reject<=1.
//      otherwise: stake<=amt, side<=bet_side, balance<=balance-amt, bet_locked<=1.
//    Any case -> LOCKED. Balance change is visible the cycle after the strobe edge.
//  LOCKED:
//    Switch changes and further round_start strobes are ignored.
//    First edge with endround==1 settles on that edge -> DONE:
//      win = (pscore>dscore && side==01) || (dscore>pscore && side==10).
//      win:                        pay=2*stake, result=01.
//      tie && side==11:            pay=(TIE_MULT+1)*stake, result=01.
//      tie && side in {01,10}:     pay=stake, result=11.
//      side==00:                   pay=0, result=00.
//      otherwise:                  pay=0, result=10.
//    balance <= min(balance+pay, 2^BAL_W-1); sat<=1 if clipped.
//    Then stake<=0, bet_locked<=0.
//  DONE:
//    result is held. endround==0 -> IDLE.
//    round_start while endround still high -> treated as IDLE start (new round).
//  Arithmetic: pay and sum are computed in BAL_W+4 bits (max 9*255+255), then saturated.
//    Never wraps.
//  Simultaneous round_start & endround in IDLE: start wins; endround is evaluated next cycle in LOCKED.
//  endround high in IDLE without a start: ignored.
//  Reset mid-round: escrowed stake is forfeited; balance=START_BALANCE.
//  broke=1 still permits rounds; any bet amt>0 is rejected.
// STRUCTURE
//  Shared header baccarat_defs.vh holds:
//    side codes (SIDE_NONE/PLAYER/DEALER/TIE), result codes, state encodings.
//  One sub-module, wager_payout: combinational (side, stake, pscore, dscore) -> (pay, result).
//    Parameterised by BAL_W and TIE_MULT.
//  Top: the 3-state FSM plus balance/stake/side registers.
// TESTING
//  1. Reset -> balance=100. side=01, amt=20, start -> balance=80, locked=1.
//     p=7, d=5, endround -> balance=120, result=01.
//  2. side=10, amt=30 from 100; p=9, d=2 -> balance=70, result=10.
//     endround low -> IDLE, result held until next start.
//  3. side=11, amt=10 from 100; p=d=6 -> balance=90+90=180, result=01.
//     side=01, amt=10 on tie -> balance unchanged 100, result=11.
//  4. amt=150 > balance=100, start -> bet_reject=1, locked=0, balance=100.
//     Settle -> result=00.
//  5. balance=250, side=11, amt=200 -> 50+1800 clips to 255, sat=1.
//     Start and endround in the same cycle from IDLE -> settles one cycle later.
//  6. Assert resetb in LOCKED with stake=40 -> balance=100 immediately (async), state IDLE, locked=0.

Source files
------------

// File: rtl/wager_controller_pkg.sv
// Shared codes for the baccarat wager path: bet sides, round results and controller states.
package wager_controller_pkg;

  localparam logic [1:0] SIDE_NONE   = 2'b00;
  localparam logic [1:0] SIDE_PLAYER = 2'b01;
  localparam logic [1:0] SIDE_DEALER = 2'b10;
  localparam logic [1:0] SIDE_TIE    = 2'b11;

  localparam logic [1:0] RES_NONE = 2'b00;
  localparam logic [1:0] RES_WIN  = 2'b01;
  localparam logic [1:0] RES_LOSE = 2'b10;
  localparam logic [1:0] RES_PUSH = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_LOCKED = 2'b01,
    ST_DONE   = 2'b10
  } wager_state_t;

endpackage

// File: rtl/wager_controller_payout.sv
// Combinational payout rules: maps the escrowed bet and final scores to a return amount and result code.
module wager_payout
  import wager_controller_pkg::*;
#(
  parameter int unsigned BAL_W    = 8,
  parameter int unsigned TIE_MULT = 8
) (
  input  logic [1:0]       side,
  input  logic [BAL_W-1:0] stake,
  input  logic [3:0]       pscore,
  input  logic [3:0]       dscore,
  output logic [BAL_W+3:0] pay,
  output logic [1:0]       result
);

  localparam int unsigned PW = BAL_W + 4;

  logic [PW-1:0] stake_w;
  logic          tie;
  logic          win;

  assign stake_w = PW'(stake);
  assign tie     = (pscore == dscore);
  assign win     = ((pscore > dscore) && (side == SIDE_PLAYER)) ||
                   ((dscore > pscore) && (side == SIDE_DEALER));

  always_comb begin
    pay    = '0;
    result = RES_NONE;
    if (side == SIDE_NONE) begin
      pay    = '0;
      result = RES_NONE;
    end else if (win) begin
      pay    = stake_w << 1;
      result = RES_WIN;
    end else if (tie && (side == SIDE_TIE)) begin
      pay    = stake_w * PW'(TIE_MULT + 1);
      result = RES_WIN;
    end else if (tie) begin
      pay    = stake_w;
      result = RES_PUSH;
    end else begin
      pay    = '0;
      result = RES_LOSE;
    end
  end

endmodule

// File: rtl/wager_controller.sv
// Baccarat wager sequencer: escrows the bet at round start and settles it with saturation at round end.
module wager_controller
  import wager_controller_pkg::*;
#(
  parameter int unsigned START_BALANCE = 100,
  parameter int unsigned BAL_W         = 8,
  parameter int unsigned TIE_MULT      = 8
) (
  input  logic             slow_clock,
  input  logic             resetb,
  input  logic             round_start,
  input  logic             endround,
  input  logic [3:0]       pscore,
  input  logic [3:0]       dscore,
  input  logic [1:0]       bet_side,
  input  logic [BAL_W-1:0] bet_amt,
  output logic [BAL_W-1:0] balance,
  output logic             bet_locked,
  output logic             bet_reject,
  output logic [1:0]       result,
  output logic             sat,
  output logic             broke
);

  localparam int unsigned PW = BAL_W + 4;

  wager_state_t     state;
  logic [BAL_W-1:0] stake;
  logic [1:0]       side;
  logic [PW-1:0]    pay;
  logic [1:0]       pay_result;
  logic [PW-1:0]    sum;
  logic             clip;
  logic             do_start;
  logic             do_settle;

  wager_payout #(
    .BAL_W    (BAL_W),
    .TIE_MULT (TIE_MULT)
  ) u_payout (
    .side   (side),
    .stake  (stake),
    .pscore (pscore),
    .dscore (dscore),
    .pay    (pay),
    .result (pay_result)
  );

  assign sum   = PW'(balance) + pay;
  assign clip  = (sum > PW'({BAL_W{1'b1}}));
  assign broke = (balance == '0);

  // A start strobe in DONE (endround still high) begins a new round exactly as from IDLE.
  assign do_start  = round_start && ((state == ST_IDLE) || (state == ST_DONE));
  assign do_settle = (state == ST_LOCKED) && endround;

  always_ff @(posedge slow_clock or negedge resetb) begin
    if (!resetb) begin
      state      <= ST_IDLE;
      balance    <= BAL_W'(START_BALANCE);
      stake      <= '0;
      side       <= SIDE_NONE;
      bet_locked <= 1'b0;
      bet_reject <= 1'b0;
      result     <= RES_NONE;
      sat        <= 1'b0;
    end else if (do_start) begin
      state  <= ST_LOCKED;
      result <= RES_NONE;
      if ((bet_side == SIDE_NONE) || (bet_amt == '0) || (bet_amt > balance)) begin
        stake      <= '0;
        side       <= SIDE_NONE;
        bet_locked <= 1'b0;
        bet_reject <= (bet_side != SIDE_NONE) && (bet_amt != '0);
      end else begin
        stake      <= bet_amt;
        side       <= bet_side;
        balance    <= balance - bet_amt;
        bet_locked <= 1'b1;
        bet_reject <= 1'b0;
      end
    end else if (do_settle) begin
      state      <= ST_DONE;
      balance    <= clip ? '1 : sum[BAL_W-1:0];
      sat        <= sat | clip;
      result     <= pay_result;
      stake      <= '0;
      bet_locked <= 1'b0;
    end else if ((state == ST_DONE) && !endround) begin
      state <= ST_IDLE;
    end
  end

endmodule

// File: tb/tb_wager_controller.sv
// Directed self-checking bench for wager_controller with hand-computed expectations.
module tb_wager_controller;

  logic       slow_clock = 1'b0;
  logic       resetb;
  logic       round_start;
  logic       endround;
  logic [3:0] pscore;
  logic [3:0] dscore;
  logic [1:0] bet_side;
  logic [7:0] bet_amt;
  logic [7:0] balance;
  logic       bet_locked;
  logic       bet_reject;
  logic [1:0] result;
  logic       sat;
  logic       broke;

  int n_cmp = 0;
  int n_err = 0;

  wager_controller #(
    .START_BALANCE (100),
    .BAL_W         (8),
    .TIE_MULT      (8)
  ) dut (
    .slow_clock  (slow_clock),
    .resetb      (resetb),
    .round_start (round_start),
    .endround    (endround),
    .pscore      (pscore),
    .dscore      (dscore),
    .bet_side    (bet_side),
    .bet_amt     (bet_amt),
    .balance     (balance),
    .bet_locked  (bet_locked),
    .bet_reject  (bet_reject),
    .result      (result),
    .sat         (sat),
    .broke       (broke)
  );

  always #5 slow_clock = ~slow_clock;

  task automatic step();
    @(posedge slow_clock);
    #1;
  endtask

  task automatic check(input string tag, input int observed, input int expected);
    n_cmp++;
    assert (observed === expected)
    else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, observed, expected);
    end
  endtask

  task automatic do_reset();
    round_start = 1'b0;
    endround    = 1'b0;
    resetb      = 1'b0;
    #3;
    resetb = 1'b1;
    step();
  endtask

  task automatic start_bet(input logic [1:0] s, input logic [7:0] a);
    bet_side    = s;
    bet_amt     = a;
    round_start = 1'b1;
    step();
    round_start = 1'b0;
  endtask

  task automatic settle(input logic [3:0] p, input logic [3:0] d);
    pscore   = p;
    dscore   = d;
    endround = 1'b1;
    step();
  endtask

  task automatic finish_round();
    endround = 1'b0;
    step();
  endtask

  initial begin
    resetb = 1'b0; round_start = 1'b0; endround = 1'b0;
    pscore = '0; dscore = '0; bet_side = '0; bet_amt = '0;
    #12;
    check("rst_balance", balance, 100);
    check("rst_locked", bet_locked, 0);
    check("rst_reject", bet_reject, 0);
    check("rst_result", result, 0);
    check("rst_sat", sat, 0);
    check("rst_broke", broke, 0);
    resetb = 1'b1;
    step();

    // 1: player wins
    start_bet(2'b01, 8'd20);
    check("t1_escrow_bal", balance, 80);
    check("t1_locked", bet_locked, 1);
    settle(4'd7, 4'd5);
    check("t1_bal", balance, 120);
    check("t1_result", result, 1);
    check("t1_unlocked", bet_locked, 0);
    finish_round();
    check("t1_result_held", result, 1);

    // 2: dealer bet loses
    do_reset();
    start_bet(2'b10, 8'd30);
    check("t2_escrow_bal", balance, 70);
    settle(4'd9, 4'd2);
    check("t2_bal", balance, 70);
    check("t2_result", result, 2);
    finish_round();
    step();
    check("t2_result_held", result, 2);

    // 3a: tie bet wins
    do_reset();
    start_bet(2'b11, 8'd10);
    check("t3a_escrow_bal", balance, 90);
    settle(4'd6, 4'd6);
    check("t3a_bal", balance, 180);
    check("t3a_result", result, 1);
    finish_round();

    // 3b: player bet pushes on tie
    do_reset();
    start_bet(2'b01, 8'd10);
    settle(4'd6, 4'd6);
    check("t3b_bal", balance, 100);
    check("t3b_result", result, 3);
    finish_round();

    // 4: over-balance bet rejected
    do_reset();
    start_bet(2'b01, 8'd150);
    check("t4_reject", bet_reject, 1);
    check("t4_locked", bet_locked, 0);
    check("t4_bal", balance, 100);
    settle(4'd8, 4'd1);
    check("t4_result", result, 0);
    check("t4_bal_after", balance, 100);
    finish_round();

    // 5: build to 250, then a clipped tie payout with start and endround together
    do_reset();
    start_bet(2'b11, 8'd15);
    settle(4'd3, 4'd3);
    check("t5_bal_220", balance, 220);
    finish_round();
    start_bet(2'b01, 8'd30);
    settle(4'd8, 4'd4);
    check("t5_bal_250", balance, 250);
    check("t5_sat_clear", sat, 0);
    finish_round();
    pscore = 4'd5; dscore = 4'd5;
    bet_side = 2'b11; bet_amt = 8'd200;
    round_start = 1'b1; endround = 1'b1;
    step();
    round_start = 1'b0;
    check("t5_same_cycle_bal", balance, 50);
    check("t5_same_cycle_locked", bet_locked, 1);
    check("t5_same_cycle_result", result, 0);
    step();
    check("t5_clip_bal", balance, 255);
    check("t5_sat", sat, 1);
    check("t5_result", result, 1);
    finish_round();
    step();
    check("t5_sat_sticky", sat, 1);

    // broke: lose everything, then any stake is refused
    do_reset();
    start_bet(2'b01, 8'd100);
    check("brk_escrow_broke", broke, 1);
    settle(4'd2, 4'd9);
    check("brk_bal", balance, 0);
    check("brk_broke", broke, 1);
    finish_round();
    start_bet(2'b10, 8'd1);
    check("brk_reject", bet_reject, 1);
    check("brk_locked", bet_locked, 0);
    finish_round();

    // 6: async reset while a stake is escrowed
    do_reset();
    start_bet(2'b01, 8'd40);
    check("t6_escrow_bal", balance, 60);
    #2;
    resetb = 1'b0;
    #1;
    check("t6_async_bal", balance, 100);
    check("t6_async_locked", bet_locked, 0);
    resetb = 1'b1;
    step();
    // endround without a start must be ignored in IDLE
    pscore = 4'd9; dscore = 4'd0;
    endround = 1'b1;
    step();
    step();
    check("t6_idle_bal", balance, 100);
    check("t6_idle_result", result, 0);
    endround = 1'b0;
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
